// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - bus-side handshake bundle of the UART receiver
//
// Purpose: groups the enable, consume handshake, held byte and status flags of
//          uart_rx so the CPU/bus side connects through a single port.
// Signals:
//   cs          receiver enable (bus -> receiver)
//   rx_ack      consume held byte and clear flags (bus -> receiver)
//   rx_byte     last good byte, LSb received first (receiver -> bus)
//   rx_ready    rx_byte holds an unconsumed byte (receiver -> bus)
//   frame_error sticky, a stop bit was sampled low (receiver -> bus)
//   overrun     sticky, a frame completed while rx_ready was high (receiver -> bus)
//   busy        receiver is not idle (receiver -> bus)
// Modports: master = bus/CPU side, slave = receiver.

interface uart_rx_if;
   logic       cs;
   logic       rx_ack;
   logic [7:0] rx_byte;
   logic       rx_ready;
   logic       frame_error;
   logic       overrun;
   logic       busy;

   modport master (
      output cs, rx_ack,
      input  rx_byte, rx_ready, frame_error, overrun, busy
   );

   modport slave (
      input  cs, rx_ack,
      output rx_byte, rx_ready, frame_error, overrun, busy
   );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1/8N2 UART receiver with one-deep holding register
//
// Purpose: synchronises the asynchronous rx line, validates the start bit at
//          mid-bit, majority-votes every data and stop bit, and holds the
//          received byte behind a ready/ack handshake with sticky error flags.
// Parameters:
//   CLKS_PER_BIT  sourceClk cycles per bit (8..65535)
//   STOP_BITS     number of stop bits checked (1 or 2)
// Ports:
//   sourceClk  system clock
//   reset      asynchronous, active-high reset
//   rx_in      serial line, idles high, asynchronous to sourceClk
//   bus        uart_rx_if.slave: cs, rx_ack in; rx_byte, rx_ready,
//              frame_error, overrun, busy out

module uart_rx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int STOP_BITS    = 1
) (
   input  logic     sourceClk,
   input  logic     reset,
   input  logic     rx_in,
   uart_rx_if.slave bus
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_DELIVER,
      ST_WAIT_HIGH
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_cnt;
   logic [1:0]    stop_cnt;
   logic [7:0]    shift;

   logic [7:0]    byte_q;
   logic          ready_q;
   logic          fe_q;
   logic          ovr_q;
   logic          busy_q;

   logic          sync1;
   logic          sync2;
   logic [2:0]    hist;
   logic          vote;

   // Two-flop synchroniser followed by a 3-deep history for majority voting;
   // all reset to the idle (high) line level so reset never looks like a start.
   always_ff @(posedge sourceClk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         hist  <= 3'b111;
      end else begin
         sync1 <= rx_in;
         sync2 <= sync1;
         hist  <= {hist[1:0], sync2};
      end
   end

   assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

   always_ff @(posedge sourceClk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         stop_cnt <= '0;
         shift    <= '0;
         byte_q   <= '0;
         ready_q  <= 1'b0;
         fe_q     <= 1'b0;
         ovr_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         // Ack clears first; any flag set or delivery below in the same cycle wins.
         if (bus.rx_ack) begin
            ready_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (!sync2 && bus.cs) begin
                  state  <= ST_START;
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end
            end

            ST_START: begin
               if (!bus.cs) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else if (cnt == HALF_BIT) begin
                  if (vote) begin
                     // Line went back high before mid-bit: treat as a glitch.
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     state   <= ST_DATA;
                     cnt     <= '0;
                     bit_cnt <= '0;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            ST_DATA: begin
               if (!bus.cs) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else if (cnt == LAST_CNT) begin
                  shift   <= {vote, shift[7:1]};
                  cnt     <= '0;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state    <= ST_STOP;
                     stop_cnt <= 2'(STOP_BITS);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            ST_STOP: begin
               if (!bus.cs) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  if (!vote) begin
                     fe_q  <= 1'b1;
                     state <= ST_WAIT_HIGH;
                  end else begin
                     stop_cnt <= stop_cnt - 2'd1;
                     if (stop_cnt == 2'd1) begin
                        state <= ST_DELIVER;
                     end
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            ST_DELIVER: begin
               // A coincident ack frees the holding register, so the new byte lands.
               if (!ready_q || bus.rx_ack) begin
                  byte_q  <= shift;
                  ready_q <= 1'b1;
               end else begin
                  ovr_q <= 1'b1;
               end
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end

            ST_WAIT_HIGH: begin
               // Hold off through a break so a long low is not seen as a new start.
               if (sync2) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end

            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx_byte     = byte_q;
   assign bus.rx_ready    = ready_q;
   assign bus.frame_error = fe_q;
   assign bus.overrun     = ovr_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (1 and 2 stop bits)

module tb_uart_rx;

   localparam int CPB = 16;

   logic clk;
   logic rst;
   logic rx1;
   logic rx2;

   uart_rx_if b1 ();
   uart_rx_if b2 ();

   uart_rx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
      .sourceClk(clk),
      .reset    (rst),
      .rx_in    (rx1),
      .bus      (b1)
   );

   uart_rx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .sourceClk(clk),
      .reset    (rst),
      .rx_in    (rx2),
      .bus      (b2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] q1[$];
   logic       auto1 = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic       stop_ok;
      logic [7:0] exp_byte;
      logic       exp_ready;
      logic       exp_fe;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one frame on the chosen line; bit k starts at floor(k*CPB*skew/100)
   // cycles after the call. Leaves the line at the last stop level.
   task automatic send_frame(input int which, input logic [7:0] d, input logic s1,
                             input logic s2, input int nstop, input int skew);
      logic bits [0:10];
      int   t0;
      int   t1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = d[i];
      bits[9]  = s1;
      bits[10] = s2;
      for (int i = 0; i < 9 + nstop; i++) begin
         if (which == 1) rx1 = bits[i];
         else            rx2 = bits[i];
         t0 = (i * CPB * skew) / 100;
         t1 = ((i + 1) * CPB * skew) / 100;
         wait_cycles(t1 - t0);
      end
   endtask

   task automatic ack(input int which);
      if (which == 1) b1.rx_ack = 1'b1;
      else            b2.rx_ack = 1'b1;
      wait_cycles(1);
      b1.rx_ack = 1'b0;
      b2.rx_ack = 1'b0;
   endtask

   // Consumer: records every byte offered on DUT1 and acks it.
   initial begin
      forever begin
         @(negedge clk);
         if (auto1 && b1.rx_ready) begin
            q1.push_back(b1.rx_byte);
            b1.rx_ack = 1'b1;
            @(posedge clk);
            #1;
            b1.rx_ack = 1'b0;
         end
      end
   end

   initial begin
      vec_t       vecs [6];
      logic [7:0] exp_q[$];
      logic [7:0] stream [3];
      int         n;
      int         busy_cnt;
      int         k;
      logic [7:0] first;

      rst = 1'b1;
      rx1 = 1'b1;
      rx2 = 1'b1;
      b1.cs = 1'b1;
      b2.cs = 1'b1;
      b1.rx_ack = 1'b0;
      b2.rx_ack = 1'b0;
      wait_cycles(3);

      check("reset rx_byte", b1.rx_byte, 8'h00);
      check("reset rx_ready", b1.rx_ready, 0);
      check("reset frame_error", b1.frame_error, 0);
      check("reset overrun", b1.overrun, 0);
      check("reset busy", b1.busy, 0);
      rst = 1'b0;
      wait_cycles(3);

      // Latency: line falls just after edge 0; expect ready after edge
      // 2 sync + 1 detect + CPB/2 + 1 start eval + 9*CPB bits + 1 deliver.
      n = 0;
      fork
         send_frame(1, 8'hA5, 1'b1, 1'b1, 1, 100);
         begin
            do begin
               wait_cycles(1);
               n++;
            end while (!b1.rx_ready && n < 400);
         end
      join
      check("latency A5", n, 2 + 1 + CPB / 2 + 1 + 9 * CPB + 1);
      check("A5 byte", b1.rx_byte, 8'hA5);
      check("A5 frame_error", b1.frame_error, 0);
      check("A5 overrun", b1.overrun, 0);
      ack(1);
      check("A5 ack clears ready", b1.rx_ready, 0);

      vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[3] = '{8'h3C, 1'b0, 8'hFF, 1'b0, 1'b1};
      vecs[4] = '{8'h81, 1'b1, 8'h81, 1'b1, 1'b0};
      vecs[5] = '{8'h7E, 1'b1, 8'h7E, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         send_frame(1, vecs[i].data, vecs[i].stop_ok, 1'b1, 1, 100);
         rx1 = 1'b1;
         wait_cycles(8);
         check($sformatf("vec%0d byte", i), b1.rx_byte, vecs[i].exp_byte);
         check($sformatf("vec%0d ready", i), b1.rx_ready, vecs[i].exp_ready);
         check($sformatf("vec%0d frame_error", i), b1.frame_error, vecs[i].exp_fe);
         ack(1);
         check($sformatf("vec%0d after ack", i), {b1.rx_ready, b1.frame_error, b1.overrun}, 0);
      end

      // 3-cycle glitch on idle line
      busy_cnt = 0;
      rx1 = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (i == 3) rx1 = 1'b1;
         wait_cycles(1);
         if (b1.busy) busy_cnt++;
      end
      check("glitch busy 1..11", (busy_cnt >= 1 && busy_cnt <= 11), 1);
      check("glitch flags", {b1.rx_ready, b1.frame_error, b1.overrun, b1.busy}, 0);

      // Bad stop bit followed by a break, then a good frame
      send_frame(1, 8'h3C, 1'b0, 1'b1, 1, 100);
      wait_cycles(40);
      check("break busy held", b1.busy, 1);
      check("break frame_error", b1.frame_error, 1);
      check("break ready", b1.rx_ready, 0);
      rx1 = 1'b1;
      wait_cycles(6);
      check("break released busy", b1.busy, 0);
      send_frame(1, 8'h55, 1'b1, 1'b1, 1, 100);
      wait_cycles(2);
      check("55 byte", b1.rx_byte, 8'h55);
      check("55 ready", b1.rx_ready, 1);
      check("55 frame_error sticky", b1.frame_error, 1);
      ack(1);
      check("55 ack clears", {b1.rx_ready, b1.frame_error}, 0);

      // Overrun
      send_frame(1, 8'h11, 1'b1, 1'b1, 1, 100);
      send_frame(1, 8'h22, 1'b1, 1'b1, 1, 100);
      wait_cycles(2);
      check("overrun byte kept", b1.rx_byte, 8'h11);
      check("overrun flag", b1.overrun, 1);
      check("overrun ready", b1.rx_ready, 1);
      ack(1);
      check("overrun ack clears", {b1.rx_ready, b1.frame_error, b1.overrun}, 0);
      send_frame(1, 8'h33, 1'b1, 1'b1, 1, 100);
      wait_cycles(2);
      check("33 byte", b1.rx_byte, 8'h33);
      check("33 ready", b1.rx_ready, 1);
      ack(1);

      // cs dropped mid-frame aborts with no delivery
      fork
         send_frame(1, 8'h5A, 1'b1, 1'b1, 1, 100);
         begin
            wait_cycles(50);
            check("cs busy before drop", b1.busy, 1);
            b1.cs = 1'b0;
            wait_cycles(1);
            check("cs drop idle", b1.busy, 0);
         end
      join
      wait_cycles(4);
      b1.cs = 1'b1;
      check("cs drop no delivery", {b1.rx_ready, b1.frame_error, b1.overrun}, 0);

      // Asynchronous reset mid-frame with a byte held
      send_frame(1, 8'h77, 1'b1, 1'b1, 1, 100);
      wait_cycles(2);
      fork
         send_frame(1, 8'hFF, 1'b1, 1'b1, 1, 100);
         begin
            wait_cycles(60);
            check("pre-reset busy", b1.busy, 1);
            #3 rst = 1'b1;
            #1;
            check("async reset byte", b1.rx_byte, 8'h00);
            check("async reset flags", {b1.rx_ready, b1.frame_error, b1.overrun, b1.busy}, 0);
            wait_cycles(2);
            rst = 1'b0;
         end
      join
      wait_cycles(4);
      check("post-reset idle", {b1.rx_ready, b1.busy}, 0);
      send_frame(1, 8'h81, 1'b1, 1'b1, 1, 100);
      wait_cycles(2);
      check("81 after reset", b1.rx_byte, 8'h81);
      ack(1);

      // Two stop bits: second one low
      send_frame(2, 8'h96, 1'b1, 1'b0, 2, 100);
      rx2 = 1'b1;
      wait_cycles(8);
      check("2stop frame_error", b2.frame_error, 1);
      check("2stop ready", b2.rx_ready, 0);
      ack(2);
      send_frame(2, 8'hC3, 1'b1, 1'b1, 2, 100);
      wait_cycles(2);
      check("2stop good byte", b2.rx_byte, 8'hC3);
      check("2stop good flags", {b2.rx_ready, b2.frame_error, b2.overrun}, 3'b100);
      ack(2);

      // Skewed back-to-back streams with ack after each
      stream[0] = 8'h00;
      stream[1] = 8'hFF;
      stream[2] = 8'h5A;
      for (int s = 0; s < 2; s++) begin
         q1.delete();
         auto1 = 1'b1;
         for (int i = 0; i < 3; i++)
            send_frame(1, stream[i], 1'b1, 1'b1, 1, (s == 0) ? 103 : 97);
         n = 0;
         while (q1.size() < 3 && n < 1000) begin
            wait_cycles(1);
            n++;
         end
         wait_cycles(2);
         auto1 = 1'b0;
         check($sformatf("skew%0d count", s), q1.size(), 3);
         for (int i = 0; i < 3; i++)
            check($sformatf("skew%0d byte%0d", s, i), (i < q1.size()) ? q1[i] : 8'hxx, stream[i]);
         check($sformatf("skew%0d flags", s), {b1.frame_error, b1.overrun}, 0);
      end

      // Two-stop receiver, fast stream, ack after each
      for (int i = 0; i < 3; i++) begin
         send_frame(2, stream[i], 1'b1, 1'b1, 2, 103);
         check($sformatf("2stop skew byte%0d", i), b2.rx_byte, stream[i]);
         check($sformatf("2stop skew flags%0d", i), {b2.rx_ready, b2.frame_error, b2.overrun}, 3'b100);
         b2.rx_ack = 1'b1;
         wait_cycles(1);
         b2.rx_ack = 1'b0;
      end

      // Random bytes, gaps and mild skew against a queue of what was sent
      q1.delete();
      exp_q.delete();
      auto1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         first = 8'($urandom);
         exp_q.push_back(first);
         send_frame(1, first, 1'b1, 1'b1, 1, $urandom_range(98, 102));
         wait_cycles($urandom_range(0, 20));
      end
      n = 0;
      while (q1.size() < exp_q.size() && n < 1000) begin
         wait_cycles(1);
         n++;
      end
      wait_cycles(2);
      auto1 = 1'b0;
      check("random count", q1.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("random byte%0d", i), (i < q1.size()) ? q1[i] : 8'hxx, exp_q[i]);
      check("random flags", {b1.frame_error, b1.overrun}, 0);

      // Random unacknowledged bursts: first byte kept, overrun iff more than one
      for (int it = 0; it < 3; it++) begin
         k = $urandom_range(1, 3);
         first = 8'($urandom);
         send_frame(1, first, 1'b1, 1'b1, 1, 100);
         for (int j = 1; j < k; j++) send_frame(1, 8'($urandom), 1'b1, 1'b1, 1, 100);
         wait_cycles(2);
         check($sformatf("burst%0d byte", it), b1.rx_byte, first);
         check($sformatf("burst%0d overrun", it), b1.overrun, (k > 1));
         check($sformatf("burst%0d ready", it), b1.rx_ready, 1);
         ack(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
